// File: rtl/ssd1306_pkg.sv
// Shared SSD1306 definitions: command opcodes, parser states and address-width helper.
package ssd1306_pkg;

  localparam int unsigned DEF_COLS  = 128;
  localparam int unsigned DEF_PAGES = 8;

  localparam logic [7:0] CMD_MEMORYMODE       = 8'h20;
  localparam logic [7:0] CMD_COLUMNADDR       = 8'h21;
  localparam logic [7:0] CMD_PAGEADDR         = 8'h22;
  localparam logic [7:0] CMD_SETCONTRAST      = 8'h81;
  localparam logic [7:0] CMD_CHARGEPUMP       = 8'h8D;
  localparam logic [7:0] CMD_SETMULTIPLEX     = 8'hA8;
  localparam logic [7:0] CMD_DISPLAYOFF       = 8'hAE;
  localparam logic [7:0] CMD_DISPLAYON        = 8'hAF;
  localparam logic [7:0] CMD_SETDISPLAYOFFSET = 8'hD3;
  localparam logic [7:0] CMD_SETDISPLAYCLKDIV = 8'hD5;
  localparam logic [7:0] CMD_SETPRECHARGE     = 8'hD9;
  localparam logic [7:0] CMD_SETCOMPINS       = 8'hDA;
  localparam logic [7:0] CMD_SETVCOMDETECT    = 8'hDB;

  // Synchroniser idle pattern, packed as {rst, dc, cs, clk, din}
  localparam logic [4:0] SYNC_IDLE = 5'b10100;

  typedef enum logic [2:0] {
    P_CMD    = 3'd0,
    P_COL_S  = 3'd1,
    P_COL_E  = 3'd2,
    P_PAGE_S = 3'd3,
    P_PAGE_E = 3'd4,
    P_SKIP1  = 3'd5
  } parser_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_one_arg_cmd(input logic [7:0] op);
    case (op)
      CMD_MEMORYMODE, CMD_SETCONTRAST, CMD_CHARGEPUMP, CMD_SETMULTIPLEX,
      CMD_SETDISPLAYOFFSET, CMD_SETDISPLAYCLKDIV, CMD_SETPRECHARGE,
      CMD_SETCOMPINS, CMD_SETVCOMDETECT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_rx_deser.sv
// SPI pin synchronisers, spi_clk rising-edge detect and MSB-first byte shifter.
module spi_rx_deser
  import ssd1306_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_din,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_dc,
  input  logic       spi_rst,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       abort,
  output logic       soft_rst
);

  logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
  logic       din_s, sclk_s, cs_s, dc_s, rst_s;
  logic       sclk_prev_q, cs_prev_q;
  logic       sclk_rise, cs_rise;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_dc_q, rx_dc_d;
  logic       abort_q, abort_d;

  assign {rst_s, dc_s, cs_s, sclk_s, din_s} = sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  always_comb begin
    sync_d[0] = {spi_rst, spi_dc, spi_cs, spi_clk, spi_din};
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    rx_valid_d = 1'b0;
    rx_byte_d  = rx_byte_q;
    rx_dc_d    = rx_dc_q;
    abort_d    = 1'b0;
    // A clock edge seen while deselected is treated like a deselect
    if (cs_rise || (sclk_rise && cs_s)) begin
      cnt_d   = '0;
      abort_d = (cnt_q != 3'd0);
    end else if (sclk_rise) begin
      shift_d = {shift_q[6:0], din_s};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        rx_valid_d = 1'b1;
        rx_byte_d  = {shift_q[6:0], din_s};
        rx_dc_d    = dc_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q      <= {SYNC_STAGES{SYNC_IDLE}};
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sync_q      <= sync_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || !rst_s) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      rx_dc_q    <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      rx_dc_q    <= rx_dc_d;
      abort_q    <= abort_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_byte  = rx_byte_q;
  assign rx_dc    = rx_dc_q;
  assign abort    = abort_q;
  assign soft_rst = ~rst_s;

endmodule

// File: rtl/ssd1306_spi_rx.sv
// SSD1306 SPI receiver: command parser and horizontal-mode framebuffer address generator.
// Define SSD1306_RX_ERR_EN to report discarded partial bytes on rx_err/err_count.
module ssd1306_spi_rx
  import ssd1306_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COLS        = DEF_COLS,
  parameter int unsigned PAGES       = DEF_PAGES
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  spi_din,
  input  logic                                  spi_clk,
  input  logic                                  spi_cs,
  input  logic                                  spi_dc,
  input  logic                                  spi_rst,
  output logic                                  rx_valid,
  output logic [7:0]                            rx_byte,
  output logic                                  rx_dc,
  output logic                                  fb_we,
  output logic [idx_w(COLS)+idx_w(PAGES)-1:0]   fb_addr,
  output logic [7:0]                            fb_data,
  output logic                                  display_on,
  output logic                                  frame_done,
  output logic                                  rx_err,
  output logic [7:0]                            err_count
);

  localparam int unsigned CW = idx_w(COLS);
  localparam int unsigned PW = idx_w(PAGES);

  logic abort, soft_rst;

  spi_rx_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .clk      (clk),
    .reset    (reset),
    .spi_din  (spi_din),
    .spi_clk  (spi_clk),
    .spi_cs   (spi_cs),
    .spi_dc   (spi_dc),
    .spi_rst  (spi_rst),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_dc    (rx_dc),
    .abort    (abort),
    .soft_rst (soft_rst)
  );

  parser_state_e   state_q, state_d;
  logic [CW-1:0]   col_start_q, col_start_d, col_end_q, col_end_d, col_q, col_d, col_pend_q, col_pend_d;
  logic [PW-1:0]   page_start_q, page_start_d, page_end_q, page_end_d, page_q, page_d, page_pend_q, page_pend_d;
  logic            display_on_q, display_on_d;
  logic            fb_we_q, fb_we_d, frame_done_q, frame_done_d;
  logic [CW+PW-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]      fb_data_q, fb_data_d;
  logic [CW-1:0]   col_arg;
  logic [PW-1:0]   page_arg;

  assign col_arg  = rx_byte[CW-1:0];
  assign page_arg = rx_byte[PW-1:0];

  always_comb begin
    state_d      = state_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    col_d        = col_q;
    col_pend_d   = col_pend_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    page_d       = page_q;
    page_pend_d  = page_pend_q;
    display_on_d = display_on_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    frame_done_d = 1'b0;
    if (rx_valid) begin
      if (rx_dc) begin
        // Data aborts any pending argument sequence and is written at the current pointer
        state_d   = P_CMD;
        fb_we_d   = 1'b1;
        fb_addr_d = {page_q, col_q};
        fb_data_d = rx_byte;
        if (col_q == col_end_q) begin
          col_d = col_start_q;
          if (page_q == page_end_q) begin
            page_d       = page_start_q;
            frame_done_d = 1'b1;
          end else begin
            page_d = page_q + PW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end else begin
        unique case (state_q)
          P_CMD: begin
            if (rx_byte == CMD_COLUMNADDR)      state_d = P_COL_S;
            else if (rx_byte == CMD_PAGEADDR)   state_d = P_PAGE_S;
            else if (is_one_arg_cmd(rx_byte))   state_d = P_SKIP1;
            else if (rx_byte == CMD_DISPLAYON)  display_on_d = 1'b1;
            else if (rx_byte == CMD_DISPLAYOFF) display_on_d = 1'b0;
          end
          P_COL_S: begin
            col_pend_d = col_arg;
            state_d    = P_COL_E;
          end
          P_COL_E: begin
            col_start_d = col_pend_q;
            col_end_d   = (col_pend_q > col_arg) ? col_pend_q : col_arg;
            col_d       = col_pend_q;
            state_d     = P_CMD;
          end
          P_PAGE_S: begin
            page_pend_d = page_arg;
            state_d     = P_PAGE_E;
          end
          P_PAGE_E: begin
            page_start_d = page_pend_q;
            page_end_d   = (page_pend_q > page_arg) ? page_pend_q : page_arg;
            page_d       = page_pend_q;
            state_d      = P_CMD;
          end
          P_SKIP1: state_d = P_CMD;
          default: state_d = P_CMD;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || soft_rst) begin
      state_q      <= P_CMD;
      col_start_q  <= '0;
      col_end_q    <= CW'(COLS - 1);
      col_q        <= '0;
      col_pend_q   <= '0;
      page_start_q <= '0;
      page_end_q   <= PW'(PAGES - 1);
      page_q       <= '0;
      page_pend_q  <= '0;
      display_on_q <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      col_q        <= col_d;
      col_pend_q   <= col_pend_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      page_q       <= page_d;
      page_pend_q  <= page_pend_d;
      display_on_q <= display_on_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign display_on = display_on_q;
  assign frame_done = frame_done_q;

`ifdef SSD1306_RX_ERR_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (abort && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset || soft_rst) err_count_q <= '0;
    else                    err_count_q <= err_count_d;
  end

  assign rx_err    = abort;
  assign err_count = err_count_q;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign rx_err       = 1'b0;
  assign err_count    = '0;
`endif

endmodule

// File: doc/ssd1306_spi_rx.md
Name: ssd1306_spi_rx

Overview:
Display-side receiver for the 4-wire SSD1306-style SPI link driven by our display SPI master (din/clk/cs/dc/rst).
- Oversamples the SPI pins in the system clock domain and deserialises bytes MSB-first.
- Decodes the command stream: column/page windows, display on/off, skipping of argument bytes.
- Turns data bytes into framebuffer writes in horizontal addressing mode.
- Used as a loopback/emulation target so that display traffic can be checked on-chip and in simulation without a panel.

Parameters:
SYNC_STAGES, 2, synchroniser depth on every SPI input (min 2)
COLS, 128, framebuffer columns (power of two)
PAGES, 8, framebuffer pages of 8 rows (power of two)

Ports:
clk  in  1  system clock; all logic on posedge clk
reset  in  1  synchronous, active-low
spi_din  in  1  serial data, MSB first
spi_clk  in  1  serial clock; idles low, data sampled on its rising edge
spi_cs  in  1  chip select, active-low
spi_dc  in  1  1 = data byte, 0 = command byte
spi_rst  in  1  panel reset, active-low
rx_valid  out  1  one-cycle pulse: byte received
rx_byte  out  8  received byte
rx_dc  out  1  dc latched with the byte
fb_we  out  1  one-cycle framebuffer write strobe
fb_addr  out  log2(COLS*PAGES)  page*COLS+col (10 bits at defaults)
fb_data  out  8  byte to write
display_on  out  1  set by 0xAF, cleared by 0xAE
frame_done  out  1  pulse with the fb_we that writes (col_end,page_end)
rx_err  out  1  see Optional Feature
err_count  out  8  see Optional Feature

Behaviour:
- Reset (reset==0) clears all outputs to 0, the shift register and bit counter, and the parser to P_CMD.
  - Windows reset to col 0..COLS-1 and page 0..PAGES-1; pointers reset to 0.
  - Synchroniser flops reset so that cs=1, clk=0, rst=1.
- Synchronised spi_rst==0 acts as a soft reset: same as reset except display_on=0; held while low.
- Rising spi_clk is detected from the last two synchronised samples.
  - On each rising edge with cs==0: shift in din and increment the bit counter.
  - On the 8th bit, latch dc; rx_valid pulses in the next clk with rx_byte/rx_dc; the bit counter returns to 0.
- cs rising, or a rising spi_clk while cs==1: discard the partial byte, bit counter to 0, parser state kept.
- Parser FSM runs on rx_valid.
  - P_CMD with dc=0:
    - 0x21 -> P_COL_S, then P_COL_E.
    - 0x22 -> P_PAGE_S, then P_PAGE_E.
    - One-arg commands (0x20,0x81,0x8D,0xA8,0xD3,0xD5,0xD9,0xDA,0xDB) -> P_SKIP1.
    - 0xAE/0xAF update display_on.
    - Any other byte is ignored.
  - Argument states consume the next dc=0 byte and return to P_CMD after the last argument.
  - Args are masked to log2 width. A start greater than end is clamped to start==end.
  - Completing COLUMNADDR sets col=col_start; completing PAGEADDR sets page=page_start.
  - A dc=1 byte arriving in any argument state aborts the command: old windows are kept, the parser goes to P_CMD, and the byte is processed as data.
- Data byte (dc=1):
  - fb_we, fb_addr and fb_data are asserted in the cycle after rx_valid (2 clk after bit-8 detect).
  - Then col++. If col==col_end: col=col_start and page++. If page==page_end as well: page=page_start and frame_done pulses with that write.
- Timing requirement: the SPI half-period must be at least SYNC_STAGES+2 clk. The link master uses 11 clk per half-period.

Optional Feature:
SSD1306_RX_ERR_EN
- Defined: a discarded partial byte (1..7 bits) pulses rx_err for one clk and increments err_count, saturating at 255. The count is cleared by reset or soft reset.
- Undefined: rx_err and err_count are tied to 0 and partial bytes are dropped silently.

Decomposition:
- Shared package ssd1306_pkg holds the command opcodes (shared with the transmitter's command definitions), the one-arg opcode list, the parser state enum, and the COLS/PAGES-derived address widths.
- One sub-module, spi_rx_deser: synchronisers, edge detect and the byte shifter. It outputs rx_valid/rx_byte/rx_dc and an abort strobe. The parser and address generator stay in the top module.

Test Plan:
- Send 0xAF as a command -> rx_valid with rx_byte=0xAF, rx_dc=0; display_on=1; no fb_we.
- Send 0x21,0,127,0x22,0,7, then 1024 data bytes 0..255 repeating -> fb_addr 0..1023 in order; frame_done only on the 1024th write; the 1025th write goes to addr 0.
- Send 0x21,10,12,0x22,2,3, then 7 data bytes -> fb_addr 266,267,268,394,395,396,266; frame_done on the 6th write.
- Send 5 bits then raise cs, then a full command 0xAE -> no rx_valid for the fragment, display_on=0. With SSD1306_RX_ERR_EN: rx_err pulse and err_count=1.
- Send 0x21,20, then a dc=1 byte 0x55 -> write 0x55 at the current pointer, window unchanged, parser back in P_CMD.
- Pull spi_rst low for 2 spi_clk periods in mid-byte or mid-argument -> pointers and windows return to defaults, display_on=0, the next data byte goes to addr 0. Assert reset mid-frame -> all outputs 0 next cycle.
